// File: rtl/adder_stim_gen.sv
// adder_stim_gen: packetised operand stimulus for adder energy runs.
// Four data patterns, valid/ready handshake and measurement window.
module adder_stim_gen #(
  parameter int W     = 23,
  parameter int STEP  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] payload_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] num_pkts,
  input  logic             ready,
  output logic [W-1:0]     operand_a,
  output logic [W-1:0]     operand_b,
  output logic             valid,
  output logic             sop,
  output logic             eop,
  output logic             busy,
  output logic             measure,
  output logic             done,
  output logic [31:0]      cycle_count
);

  localparam int DATA_W = 2 * W;
  localparam int KW     = $clog2(DATA_W);
  localparam int LW     = $clog2(2 * DATA_W + 1) + 1;

  localparam logic [KW-1:0]    K_MAX  = KW'(DATA_W - 1);
  localparam logic [LW-1:0]    L_STEP = LW'(STEP);
  localparam logic [LW-1:0]    L_DW   = LW'(DATA_W);
  localparam logic [LW-1:0]    L_2DW  = LW'(2 * DATA_W);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [31:0]      POLY   = 32'h0040_0005;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(
    input logic [1:0]    m,
    input logic [KW-1:0] k,
    input logic [LW-1:0] l,
    input logic [31:0]   s,
    input logic          t
  );
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] r;
    ones = '1;
    r    = '0;
    unique case (m)
      2'd0: r = DATA_W'(1) << k;
      2'd1: begin
        if (l <= L_DW) r = ~(ones >> l);
        else           r = ones >> (l - L_DW);
      end
      2'd2: begin
        for (int i = 0; i < DATA_W; i++)
          r[i] = s[i % 32];
      end
      default: r = t ? ones : '0;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  plen_q, plen_d;
  logic [CNT_W-1:0]  glen_q, glen_d;
  logic [CNT_W-1:0]  npkt_q, npkt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  gcnt_q, gcnt_d;
  logic [KW-1:0]     walk_q, walk_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic [LW-1:0]     lsum;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              tog_q, tog_d;
  logic [DATA_W-1:0] flit_q, flit_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic              busy_q, busy_d;
  logic              meas_q, meas_d;
  logic              done_q, done_d;
  logic [31:0]       cyc_q, cyc_d;
  logic              hs;
  logic              load_pkt;
  logic              adv;

  // Next-state, pattern and registered-output computation
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    plen_d   = plen_q;
    glen_d   = glen_q;
    npkt_d   = npkt_q;
    fcnt_d   = fcnt_q;
    pcnt_d   = pcnt_q;
    gcnt_d   = gcnt_q;
    walk_d   = walk_q;
    lvl_d    = lvl_q;
    lfsr_d   = lfsr_q;
    tog_d    = tog_q;
    flit_d   = flit_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    done_d   = 1'b0;
    cyc_d    = meas_q ? cyc_q + 32'd1 : cyc_q;
    hs       = valid_q & ready;
    load_pkt = 1'b0;
    adv      = 1'b0;
    lsum     = lvl_q + L_STEP;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d = mode;
          plen_d = (payload_len == '0) ? ONE : payload_len;
          glen_d = gap_len;
          npkt_d = num_pkts;
          lfsr_d = (seed == 32'h0) ? 32'h1 : seed;
          fcnt_d = '0;
          pcnt_d = '0;
          gcnt_d = '0;
          cyc_d  = '0;
          if (num_pkts == '0) begin
            state_d = DONE;
          end else begin
            state_d  = SEND;
            load_pkt = 1'b1;
          end
        end
      end
      SEND: begin
        if (hs) begin
          lfsr_d = lfsr_step(lfsr_q);
          if (fcnt_q == plen_q - ONE) begin
            fcnt_d = '0;
            if (pcnt_q == npkt_q - ONE) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              pcnt_d = pcnt_q + ONE;
              if (glen_q == '0) begin
                load_pkt = 1'b1;
              end else begin
                state_d = GAP;
                gcnt_d  = '0;
              end
            end
          end else begin
            fcnt_d = fcnt_q + ONE;
            adv    = 1'b1;
          end
        end
      end
      GAP: begin
        if (gcnt_q == glen_q - ONE) begin
          state_d  = SEND;
          load_pkt = 1'b1;
        end else begin
          gcnt_d = gcnt_q + ONE;
        end
      end
      default: begin
        if (done_q) state_d = IDLE;
        else        done_d  = 1'b1;
      end
    endcase

    if (load_pkt) begin
      walk_d = '0;
      lvl_d  = L_STEP;
      tog_d  = 1'b1;
      sop_d  = 1'b1;
      eop_d  = (plen_d == ONE);
      flit_d = pattern(mode_d, walk_d, lvl_d, lfsr_d, tog_d);
    end else if (adv) begin
      walk_d = (walk_q == K_MAX) ? '0 : walk_q + KW'(1);
      lvl_d  = (lsum >= L_2DW) ? lsum - L_2DW : lsum;
      tog_d  = ~tog_q;
      sop_d  = 1'b0;
      eop_d  = (fcnt_d == plen_q - ONE);
      flit_d = pattern(mode_q, walk_d, lvl_d, lfsr_d, tog_d);
    end

    valid_d = (state_d == SEND);
    busy_d  = (state_d == SEND) || (state_d == GAP);
    meas_d  = busy_d;
    if (!valid_d) begin
      sop_d = 1'b0;
      eop_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      plen_q  <= '0;
      glen_q  <= '0;
      npkt_q  <= '0;
      fcnt_q  <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
      walk_q  <= '0;
      lvl_q   <= '0;
      lfsr_q  <= '0;
      tog_q   <= 1'b0;
      flit_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      busy_q  <= 1'b0;
      meas_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      plen_q  <= plen_d;
      glen_q  <= glen_d;
      npkt_q  <= npkt_d;
      fcnt_q  <= fcnt_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      walk_q  <= walk_d;
      lvl_q   <= lvl_d;
      lfsr_q  <= lfsr_d;
      tog_q   <= tog_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      busy_q  <= busy_d;
      meas_q  <= meas_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  assign operand_a   = flit_q[W-1:0];
  assign operand_b   = flit_q[DATA_W-1:W];
  assign valid       = valid_q;
  assign sop         = sop_q;
  assign eop         = eop_q;
  assign busy        = busy_q;
  assign measure     = meas_q;
  assign done        = done_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_adder_stim_gen.sv
// tb_adder_stim_gen: randomized self-checking bench for adder_stim_gen.
// Expected flits come from a per-flit arithmetic model of the patterns.
module tb_adder_stim_gen;

  localparam int W    = 23;
  localparam int DW   = 46;
  localparam int STEP = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed = 32'h0;
  logic [15:0] payload_len = 16'd0;
  logic [15:0] gap_len = 16'd0;
  logic [15:0] num_pkts = 16'd0;
  logic        ready = 1'b1;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic        valid, sop, eop, busy, measure, done;
  logic [31:0] cycle_count;

  adder_stim_gen #(.W(W), .STEP(STEP), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .seed(seed), .payload_len(payload_len), .gap_len(gap_len),
    .num_pkts(num_pkts), .ready(ready),
    .operand_a(operand_a), .operand_b(operand_b),
    .valid(valid), .sop(sop), .eop(eop), .busy(busy),
    .measure(measure), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q_flit[$];
  logic [DW-1:0] e_flit[$];
  logic [DW-1:0] s_flit[$];
  bit q_sop[$], q_eop[$], e_sop[$], e_eop[$];
  int r_done, r_stalls, r_hold, r_gap, r_meas;
  logic [31:0] r_cc;

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] n;
    n = s << 1;
    if (s[31]) n = n ^ 32'h0040_0005;
    return n;
  endfunction

  function automatic logic [DW-1:0] thermo(input int lv);
    logic [DW-1:0] f;
    f = '0;
    for (int b = 0; b < DW; b++)
      f[b] = (lv <= DW) ? (b >= DW - lv) : (b < 2 * DW - lv);
    return f;
  endfunction

  task automatic build(input logic [1:0] m, input logic [31:0] sd,
                       input int p, input int n);
    logic [31:0] s;
    logic [63:0] rep;
    logic [DW-1:0] f;
    int pe;
    e_flit.delete(); e_sop.delete(); e_eop.delete();
    pe = (p == 0) ? 1 : p;
    s = (sd == 0) ? 32'h1 : sd;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < pe; j++) begin
        case (m)
          2'd0: f = 46'd1 << (j % DW);
          2'd1: f = thermo(((j + 1) * STEP) % (2 * DW));
          2'd2: begin rep = {s, s}; f = rep[DW-1:0]; end
          default: f = (j % 2 == 0) ? '1 : '0;
        endcase
        s = lstep(s);
        e_flit.push_back(f);
        e_sop.push_back(j == 0);
        e_eop.push_back(j == pe - 1);
      end
    end
  endtask

  function automatic int seq_diff();
    int d;
    d = 0;
    if (q_flit.size() != e_flit.size()) d++;
    for (int i = 0; i < q_flit.size() && i < e_flit.size(); i++)
      if (q_flit[i] !== e_flit[i] || q_sop[i] !== e_sop[i] ||
          q_eop[i] !== e_eop[i]) d++;
    return d;
  endfunction

  function automatic logic [DW-1:0] qf(input int i);
    if (i < q_flit.size()) return q_flit[i];
    return 'x;
  endfunction

  task automatic run(input logic [1:0] m, input logic [31:0] sd,
                     input int p, input int g, input int n,
                     input bit rr, input int restart_at);
    logic [DW-1:0] cur, prev;
    bit prev_stall, have_prev;
    int cyc;
    q_flit.delete(); q_sop.delete(); q_eop.delete();
    r_done = -1; r_cc = 32'hFFFF_FFFF;
    r_stalls = 0; r_hold = 0; r_gap = 0; r_meas = 0;
    @(negedge clk);
    mode = m; seed = sd;
    payload_len = 16'(p); gap_len = 16'(g); num_pkts = 16'(n);
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; prev_stall = 0; have_prev = 0; prev = '0;
    while (cyc <= 5000) begin
      ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == restart_at) begin
        start = 1'b1; mode = ~m; seed = ~sd;
        num_pkts = 16'd0; payload_len = 16'd1; gap_len = 16'd0;
      end else begin
        start = 1'b0;
      end
      cur = {operand_b, operand_a};
      if (have_prev && (prev_stall || !valid) && cur !== prev) r_hold++;
      if (valid && !ready) r_stalls++;
      if (!valid && busy) r_gap++;
      if (measure) r_meas++;
      if (valid && ready) begin
        q_flit.push_back(cur);
        q_sop.push_back(sop);
        q_eop.push_back(eop);
      end
      prev_stall = valid && !ready;
      prev = cur;
      have_prev = 1;
      if (done) begin
        r_done = cyc;
        r_cc = cycle_count;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({operand_b, operand_a} !== '0) begin
      errors++;
      $display("FAIL reset_operands got %h exp 0", {operand_b, operand_a});
    end
    checks++;
    if ({valid, sop, eop, busy, measure, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000000",
               {valid, sop, eop, busy, measure, done});
    end
    checks++;
    if (cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_cc got %0d exp 0", cycle_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_thermo();
    logic [DW-1:0] f0, f4;
    run(2'd1, 32'h0, 20, 7, 10, 1'b0, -1);
    build(2'd1, 32'h0, 20, 10);
    f0 = qf(0);
    f4 = qf(4);
    checks++;
    if (f0[45:23] !== 23'h7FE000 || f0[22:0] !== 23'h0) begin
      errors++;
      $display("FAIL thermo_flit0 got %h exp 7fe000_000000", f0);
    end
    checks++;
    if (f4[22:0] !== 23'h7FFFFF || f4[45:23] !== 23'h07FFFF) begin
      errors++;
      $display("FAIL thermo_flit4 got %h exp 07ffff_7fffff", f4);
    end
    checks++;
    if (seq_diff() != 0) begin
      errors++;
      $display("FAIL thermo_seq got %0d diffs exp 0", seq_diff());
    end
    checks++;
    if (r_done !== 264) begin
      errors++;
      $display("FAIL thermo_done got %0d exp 264", r_done);
    end
    checks++;
    if (r_cc !== 32'd263 || r_meas !== 263) begin
      errors++;
      $display("FAIL thermo_cc got %0d/%0d exp 263", r_cc, r_meas);
    end
    checks++;
    if (r_gap !== 63 || r_hold !== 0) begin
      errors++;
      $display("FAIL thermo_gap got %0d hold %0d exp 63 0", r_gap, r_hold);
    end
  endtask

  task automatic test_walk();
    logic [DW-1:0] f0, f22, f23;
    run(2'd0, 32'h0, 24, 0, 1, 1'b0, -1);
    build(2'd0, 32'h0, 24, 1);
    f0 = qf(0); f22 = qf(22); f23 = qf(23);
    checks++;
    if (f0[22:0] !== 23'h1 || f22[22:0] !== 23'h400000) begin
      errors++;
      $display("FAIL walk_a got %h %h exp 1 400000", f0[22:0], f22[22:0]);
    end
    checks++;
    if (f23[45:23] !== 23'h1 || f23[22:0] !== 23'h0) begin
      errors++;
      $display("FAIL walk_f23 got %h exp 000001_000000", f23);
    end
    checks++;
    if (seq_diff() != 0 || r_done !== 25) begin
      errors++;
      $display("FAIL walk_seq got %0d diffs done %0d exp 0 25",
               seq_diff(), r_done);
    end
  endtask

  task automatic test_toggle();
    run(2'd3, 32'h0, 4, 3, 2, 1'b0, -1);
    build(2'd3, 32'h0, 4, 2);
    checks++;
    if (seq_diff() != 0) begin
      errors++;
      $display("FAIL toggle_seq got %0d diffs exp 0", seq_diff());
    end
    checks++;
    if (r_gap !== 3 || r_hold !== 0 || qf(3) !== '0) begin
      errors++;
      $display("FAIL toggle_gap got %0d hold %0d f3 %h exp 3 0 0",
               r_gap, r_hold, qf(3));
    end
    checks++;
    if (r_done !== 12 || r_cc !== 32'd11) begin
      errors++;
      $display("FAIL toggle_done got %0d cc %0d exp 12 11", r_done, r_cc);
    end
  endtask

  task automatic test_lfsr();
    logic [DW-1:0] f0;
    int same;
    run(2'd2, 32'h0, 5, 2, 3, 1'b0, -1);
    build(2'd2, 32'h0, 5, 3);
    f0 = qf(0);
    checks++;
    if (f0[22:0] !== 23'h1) begin
      errors++;
      $display("FAIL lfsr_seed0 got %h exp 000001", f0[22:0]);
    end
    checks++;
    if (seq_diff() != 0) begin
      errors++;
      $display("FAIL lfsr_seq0 got %0d diffs exp 0", seq_diff());
    end
    run(2'd2, 32'hACE1, 6, 1, 3, 1'b0, -1);
    s_flit = q_flit;
    run(2'd2, 32'hACE1, 6, 1, 3, 1'b1, -1);
    build(2'd2, 32'hACE1, 6, 3);
    same = (s_flit.size() == q_flit.size()) ? 1 : 0;
    for (int i = 0; i < s_flit.size() && i < q_flit.size(); i++)
      if (s_flit[i] !== q_flit[i]) same = 0;
    checks++;
    if (same != 1 || s_flit.size() != 18) begin
      errors++;
      $display("FAIL lfsr_repeat got same=%0d n=%0d exp 1 18",
               same, s_flit.size());
    end
    checks++;
    if (seq_diff() != 0) begin
      errors++;
      $display("FAIL lfsr_seqACE1 got %0d diffs exp 0", seq_diff());
    end
  endtask

  task automatic test_stall();
    run(2'd1, 32'h0, 20, 7, 10, 1'b1, -1);
    build(2'd1, 32'h0, 20, 10);
    checks++;
    if (seq_diff() != 0) begin
      errors++;
      $display("FAIL stall_seq got %0d diffs exp 0", seq_diff());
    end
    checks++;
    if (r_hold !== 0 || r_stalls == 0) begin
      errors++;
      $display("FAIL stall_hold got %0d stalls %0d exp 0 >0",
               r_hold, r_stalls);
    end
    checks++;
    if (r_cc !== 32'(263 + r_stalls) || r_done !== 264 + r_stalls) begin
      errors++;
      $display("FAIL stall_cc got %0d done %0d exp %0d %0d",
               r_cc, r_done, 263 + r_stalls, 264 + r_stalls);
    end
  endtask

  task automatic test_zero_pkts();
    run(2'd0, 32'h0, 5, 3, 0, 1'b0, -1);
    checks++;
    if (r_done !== 2 || r_cc !== 32'd0) begin
      errors++;
      $display("FAIL zero_pkts got done %0d cc %0d exp 2 0", r_done, r_cc);
    end
    checks++;
    if (q_flit.size() != 0 || r_meas != 0) begin
      errors++;
      $display("FAIL zero_pkts_flits got %0d meas %0d exp 0 0",
               q_flit.size(), r_meas);
    end
  endtask

  task automatic test_back_to_back();
    run(2'd0, 32'h0, 3, 0, 3, 1'b0, -1);
    build(2'd0, 32'h0, 3, 3);
    checks++;
    if (seq_diff() != 0 || r_gap != 0) begin
      errors++;
      $display("FAIL b2b_seq got %0d diffs gap %0d exp 0 0",
               seq_diff(), r_gap);
    end
    checks++;
    if (r_done !== 10 || r_cc !== 32'd9) begin
      errors++;
      $display("FAIL b2b_done got %0d cc %0d exp 10 9", r_done, r_cc);
    end
  endtask

  task automatic test_start_busy();
    run(2'd0, 32'h0, 5, 2, 2, 1'b0, 3);
    build(2'd0, 32'h0, 5, 2);
    checks++;
    if (seq_diff() != 0 || r_done !== 13) begin
      errors++;
      $display("FAIL start_busy got %0d diffs done %0d exp 0 13",
               seq_diff(), r_done);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    mode = 2'd1; seed = 32'h0;
    payload_len = 16'd20; gap_len = 16'd7; num_pkts = 16'd10;
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({operand_b, operand_a} !== '0 || cycle_count !== 32'd0 ||
        {valid, sop, eop, busy, measure, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid got %h cc %0d flags %b exp 0",
               {operand_b, operand_a}, cycle_count,
               {valid, sop, eop, busy, measure, done});
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || valid || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_idle got %0d active cycles exp 0", bad);
    end
    run(2'd0, 32'h0, 2, 0, 1, 1'b0, -1);
    checks++;
    if (r_done !== 3 || qf(1) !== 46'd2) begin
      errors++;
      $display("FAIL reset_mid_recover got done %0d f1 %h exp 3 2",
               r_done, qf(1));
    end
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [31:0] sd;
    int p, g, n, pe, base;
    for (int it = 0; it < 6; it++) begin
      m = 2'($urandom_range(0, 3));
      sd = $urandom;
      p = $urandom_range(0, 6);
      g = $urandom_range(0, 4);
      n = $urandom_range(1, 4);
      pe = (p == 0) ? 1 : p;
      base = pe * n + (n - 1) * g;
      run(m, sd, p, g, n, 1'b1, -1);
      build(m, sd, p, n);
      checks++;
      if (seq_diff() != 0 || r_hold != 0) begin
        errors++;
        $display("FAIL rand%0d_seq got %0d diffs hold %0d exp 0 0",
                 it, seq_diff(), r_hold);
      end
      checks++;
      if (r_done !== base + 1 + r_stalls ||
          r_cc !== 32'(base + r_stalls)) begin
        errors++;
        $display("FAIL rand%0d_done got %0d cc %0d exp %0d %0d",
                 it, r_done, r_cc, base + 1 + r_stalls, base + r_stalls);
      end
    end
  endtask

  initial begin
    test_reset();
    test_thermo();
    test_walk();
    test_toggle();
    test_lfsr();
    test_stall();
    test_zero_pkts();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_stim_gen.md
# adder_stim_gen

Synthesisable, parametrised stimulus generator for adder energy characterisation. It produces a fixed number of packets, each a burst of data flits separated by idle gap cycles. Each flit is split into two W-bit operands that drive the adder under measurement. It supports four data patterns, a valid/ready handshake for back-pressured consumers, and a measurement window with a cycle count for gating power capture.

## Interface
Parameters:
- W, 23, operand width; flit width DATA_W = 2*W
- STEP, 10, thermometer level increment per flit (1..DATA_W)
- CNT_W, 16, width of the payload, gap and packet-count configuration inputs

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  2  0 walking-one, 1 thermometer, 2 LFSR, 3 toggle
- seed  in  32  LFSR seed, latched at start
- payload_len  in  CNT_W  flits per packet, latched at start
- gap_len  in  CNT_W  idle cycles between packets, latched at start
- num_pkts  in  CNT_W  packets per run, latched at start
- ready  in  1  consumer accepts the flit when ready and valid are both high
- operand_a  out  W  flit[W-1:0]
- operand_b  out  W  flit[2W-1:W]
- valid  out  1  flit present
- sop / eop  out  1  first / last flit of a packet; qualified by valid
- busy  out  1  high in SEND or GAP
- measure  out  1  measurement window
- done  out  1  one-cycle pulse at end of run
- cycle_count  out  32  cycles spent with measure high in the current/last run

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - start latches the configuration and the seed, clears the counters and cycle_count, and moves to SEND.
  - If num_pkts==0, the FSM goes to DONE instead of SEND.
  - payload_len==0 is treated as 1.
- SEND:
  - valid=1.
  - On each handshake the pattern advances and the flit counter increments.
  - Handshake on the last flit of the last packet → DONE.
  - Handshake on the last flit of any other packet → GAP, or directly to SEND for the next packet if gap_len==0.
- GAP: valid=0 for exactly gap_len cycles, then SEND.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- Pattern state resets at each packet start for modes 0, 1 and 3. The LFSR runs continuously for the whole run. Each flit emits the current state; the state advances on the handshake.
  - Walking-one: bit k set, k starts at 0, wraps DATA_W-1→0.
  - Thermometer: level L starts at STEP, L←(L+STEP) mod 2*DATA_W.
    - L≤DATA_W: top L bits are 1.
    - L>DATA_W: bottom 2*DATA_W−L bits are 1.
  - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+1. A seed of 0 is replaced by 1. Flit = low DATA_W bits of {lfsr,lfsr,…} (replicated as needed).
  - Toggle: first flit all-ones, then alternates all-zeros / all-ones.
- Operands and flit data hold their value while valid=0 (in GAP, DONE and IDLE) and while ready=0. This keeps adder inputs quiet outside flits.
- Mode is latched at start; changes during a run have no effect.

## Timing
- Reset values:
  - State IDLE.
  - operand_a, operand_b, valid, sop, eop, busy, measure, done all 0.
  - cycle_count 0.
- start sampled in cycle 0 → valid=1 and sop=1 in cycle 1 (one-cycle latency).
- measure rises with the first valid and falls after the cycle of the final handshake. cycle_count increments every cycle measure is high.
- With ready tied high, P=payload_len, G=gap_len, N=num_pkts:
  - done is asserted at cycle N*P+(N−1)*G+1 after start.
  - cycle_count at done = N*P+(N−1)*G.
- ready low stalls SEND: data, sop, eop and counters are frozen, and measure/cycle_count keep counting.
- Reset mid-run (rst_n low at an edge): all outputs return to their reset values on that edge, with no done pulse. The run is lost.

## Test plan
- W=23, STEP=10, mode=1, P=20, G=7, N=10, ready=1:
  - flit0: operand_b=23'h7FE000, operand_a=0.
  - flit4 (L=50): operand_a=23'h7FFFFF, operand_b=23'h07FFFF.
  - done at cycle 264, cycle_count=263.
- mode=0, P=24, N=1: flit0 operand_a=1; flit22 operand_a=23'h400000; flit23 operand_b=1, operand_a=0.
- mode=3, P=4, G=3, N=2: per flit, operands = all-ones, 0, all-ones, 0 in each packet; valid=0 for exactly 3 cycles with operands held at 0; sop/eop on flits 0 and 3.
- mode=2, seed=0: flit0 operand_a=1. Two runs with seed=32'hACE1 produce identical flit sequences.
- ready toggled pseudo-randomly, mode=1:
  - flit sequence is identical to the ready=1 run;
  - data is stable while valid & !ready;
  - cycle_count = 263 + number of stall cycles.
- Corners:
  - num_pkts=0 → done in cycle 2, cycle_count=0.
  - G=0 → back-to-back packets.
  - start while busy is ignored.
  - rst_n low mid-packet → all outputs 0 next cycle, FSM in IDLE.
